// File: rtl/uart_frame_decoder_pkg.sv
// uart_frame_decoder_pkg: shared frame constants, command codes, error codes and decoder states.
package uart_frame_decoder_pkg;
    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_WEIGHT = 8'd0;
    localparam logic [7:0] CMD_IMAGE  = 8'd1;
    localparam logic [7:0] CMD_START  = 8'd2;
    localparam logic [1:0] ERR_CMD     = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CHK     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN_L, S_LEN_H, S_PAYLOAD, S_CHK} state_t;
endpackage

// File: rtl/uart_frame_decoder_timeout.sv
// frame_timeout_counter: idle-cycle watchdog; load clears, run counts, expired flags the LIMIT-th idle cycle.
module frame_timeout_counter #(
    parameter int LIMIT = 50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        expired = run && !load && cnt_q == W'(LIMIT - 1);
        cnt_d   = (load || !run || expired) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: parses framed UART host commands into word writes, checksum status and start pulses.
module uart_frame_decoder #(
    parameter int         CLK_FREQ     = 50_000_000,
    parameter int         TIMEOUT_CLKS = CLK_FREQ / 1000,
    parameter int         WORD_BYTES   = 4,
    parameter int         ADDR_W       = 12,
    parameter logic [7:0] SYNC_BYTE    = uart_frame_decoder_pkg::SYNC_BYTE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_done,
    output logic                    wr_en,
    output logic                    wr_target,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    start_pulse,
    output logic                    frame_ok,
    output logic                    frame_err,
    output logic [1:0]              err_code,
    output logic                    busy
);
    import uart_frame_decoder_pkg::*;
    localparam int DW = 8 * WORD_BYTES;
    localparam int BW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d, len_l_q, len_l_d, chk_q, chk_d;
    logic [15:0]       rem_q, rem_d, len;
    logic [BW-1:0]     bpos_q, bpos_d;
    logic [DW-1:0]     word_q, word_d, wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              wr_en_q, wr_en_d, wr_target_q, wr_target_d, start_q, start_d;
    logic              ok_q, ok_d, err_q, err_d;
    logic              len_bad, last, timeout;

    frame_timeout_counter #(.LIMIT(TIMEOUT_CLKS)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (rx_done),
        .run     (busy),
        .expired (timeout)
    );

    assign len     = {rx_data, len_l_q};
    assign len_bad = (32'(len) % WORD_BYTES != 0) || (32'(len) / WORD_BYTES > 2 ** ADDR_W) ||
                     (cmd_q == CMD_START && len != 16'd0);
    assign last    = bpos_q == BW'(WORD_BYTES - 1);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_l_d     = len_l_q;
        chk_d       = chk_q;
        rem_d       = rem_q;
        bpos_d      = bpos_q;
        word_d      = word_q;
        addr_d      = addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_target_d = wr_target_q;
        err_code_d  = err_code_q;
        wr_en_d     = 1'b0;
        start_d     = 1'b0;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        if (timeout) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else if (rx_done) begin
            chk_d = chk_q ^ rx_data;
            case (state_q)
                S_IDLE: begin
                    chk_d = '0;
                    if (rx_data == SYNC_BYTE) begin
                        state_d = S_CMD;
                        addr_d  = '0;
                        bpos_d  = '0;
                    end
                end
                S_CMD: begin
                    if (rx_data > CMD_START) begin
                        state_d    = S_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_CMD;
                    end else begin
                        state_d     = S_LEN_L;
                        cmd_d       = rx_data;
                        wr_target_d = rx_data == CMD_IMAGE;
                    end
                end
                S_LEN_L: begin
                    state_d = S_LEN_H;
                    len_l_d = rx_data;
                end
                S_LEN_H: begin
                    if (len_bad) begin
                        state_d    = S_IDLE;
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end else begin
                        rem_d   = len;
                        state_d = len == 16'd0 ? S_CHK : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    word_d  = {rx_data, word_q[DW-1:8]};
                    bpos_d  = last ? '0 : bpos_q + 1'b1;
                    rem_d   = rem_q - 16'd1;
                    state_d = rem_q == 16'd1 ? S_CHK : S_PAYLOAD;
                    if (last) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = word_d;
                        wr_addr_d = addr_q;
                        addr_d    = addr_q + 1'b1;
                    end
                end
                S_CHK: begin
                    state_d    = S_IDLE;
                    ok_d       = rx_data == chk_q;
                    err_d      = rx_data != chk_q;
                    start_d    = rx_data == chk_q && cmd_q == CMD_START;
                    err_code_d = rx_data != chk_q ? ERR_CHK : err_code_q;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            len_l_q     <= '0;
            chk_q       <= '0;
            rem_q       <= '0;
            bpos_q      <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_target_q <= 1'b0;
            err_code_q  <= '0;
            wr_en_q     <= 1'b0;
            start_q     <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_l_q     <= len_l_d;
            chk_q       <= chk_d;
            rem_q       <= rem_d;
            bpos_q      <= bpos_d;
            word_q      <= word_d;
            addr_q      <= addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_target_q <= wr_target_d;
            err_code_q  <= err_code_d;
            wr_en_q     <= wr_en_d;
            start_q     <= start_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_target   = wr_target_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign start_pulse = start_q;
    assign frame_ok    = ok_q;
    assign frame_err   = err_q;
    assign err_code    = err_code_q;
    assign busy        = state_q != S_IDLE;
endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Consumes the byte stream from the UART receiver (data byte plus one-cycle done strobe) and parses framed host commands for the CNN accelerator.
- Packs payload bytes little-endian into words and issues word writes to the weight or image buffer.
- Validates each frame with an XOR checksum, reports frame OK/error, and issues the accelerator start pulse.
- Aborts a stalled frame on an inter-byte timeout.

Parameters:
- CLK_FREQ, 50_000_000, system clock in Hz.
- TIMEOUT_CLKS, CLK_FREQ/1000, max idle clocks between bytes inside a frame (1 ms).
- WORD_BYTES, 4, bytes packed per write word.
- ADDR_W, 12, word address width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- rx_data  in  8  received byte, valid when rx_done=1.
- rx_done  in  1  one-cycle byte-valid strobe from the UART receiver.
- wr_en  out  1  one-cycle word write strobe.
- wr_target  out  1  0=weight buffer, 1=image buffer.
- wr_addr  out  ADDR_W  word address, restarts at 0 every frame.
- wr_data  out  8*WORD_BYTES  packed word; first byte of the word in bits [7:0].
- start_pulse  out  1  one-cycle accelerator start.
- frame_ok  out  1  one-cycle pulse, frame passed the checksum.
- frame_err  out  1  one-cycle pulse, frame aborted.
- err_code  out  2  0=bad cmd, 1=bad len, 2=checksum, 3=timeout; held until the next frame_err.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Frame format: SYNC, CMD, LEN_L, LEN_H, LEN payload bytes, CHK. CHK = XOR of CMD, LEN_L, LEN_H and all payload bytes.
- CMD values: 0=weights, 1=image, 2=start. Any other value raises bad cmd.
- LEN rules:
  - Must be a multiple of WORD_BYTES and satisfy LEN/WORD_BYTES <= 2^ADDR_W.
  - For CMD=2, LEN must be 0. For CMD=0/1, LEN=0 is legal and produces no writes.
  - Any violation raises bad len.
- States: IDLE -> CMD -> LEN_L -> LEN_H -> PAYLOAD (skipped when LEN=0) -> CHK -> IDLE. The FSM advances only on rx_done.
- IDLE: non-SYNC bytes are ignored silently.
- CMD errors are flagged as soon as the CMD byte arrives. LEN errors are flagged as soon as the LEN_H byte arrives. In both cases: frame_err plus err_code in the following cycle, then return to IDLE.
- PAYLOAD writes:
  - A byte counter tracks the byte position within the word.
  - wr_en pulses the cycle after rx_done of each word's last byte.
  - wr_addr increments after each write.
  - wr_data and wr_addr hold their values until the next write.
- CHK: one cycle after rx_done, exactly one of two results:
  - Match: frame_ok, plus start_pulse in the same cycle when CMD=2.
  - Mismatch: frame_err with code 2.
- Writes are streamed, not buffered. On a frame error, already-written words remain in the buffer, and the host must resend the frame.
- Timeout:
  - The counter resets on every rx_done and runs only while busy.
  - Reaching TIMEOUT_CLKS raises frame_err with code 3 and returns the FSM to IDLE.
  - If rx_done arrives in the same cycle the limit is reached, the byte wins and no timeout is raised.
- After any error the decoder resynchronises on the next SYNC byte.
- Reset (asynchronous, mid-frame included):
  - State returns to IDLE; counters and the running checksum clear.
  - All outputs go to 0: wr_en, wr_target, wr_addr, wr_data, start_pulse, frame_ok, frame_err, err_code, busy.

Decomposition:
- Shared package holds:
  - SYNC_BYTE.
  - CMD codes (CMD_WEIGHT=0, CMD_IMAGE=1, CMD_START=2).
  - err_code constants.
  - FSM state encoding.
- One natural sub-module: frame_timeout_counter (load/run/expire), reusable by the transmit-side framer.

Test Plan:
- Weight frame with bytes A5 00 08 00 11 22 33 44 55 66 77 88 and correct CHK -> two writes: wr_target=0, (addr 0, data 44332211), then (addr 1, data 88776655); then one frame_ok pulse.
- Start frame A5 02 00 00 02 -> frame_ok and start_pulse in the same cycle; no wr_en.
- Image frame of length 4 with CHK off by one bit -> one write to addr 0 with wr_target=1, then frame_err with err_code=2 and no frame_ok.
- Frame A5 00 06 00 -> frame_err with err_code=1 on the cycle after LEN_H. Next A5 03 -> frame_err with err_code=0. Leading garbage bytes 00 FF -> ignored, busy stays 0.
- Bytes A5 00 04 00 11 followed by silence for TIMEOUT_CLKS -> frame_err with err_code=3, then busy=0. Repeat with the next byte landing exactly on the expiry cycle -> no error.
- Assert reset low during PAYLOAD, then release and send a valid frame -> all outputs read 0 while in reset, and the new frame writes starting at addr 0.
